// File: rtl/md_sched_unit_pkg.sv
// +----------------------------------------------------------------------+
// | md_sched_unit_pkg : op codes, FSM states and helpers for the MD unit |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package md_sched_unit_pkg;

  localparam int unsigned c_cnt_w = 4;

  localparam logic [2:0] c_md_mult  = 3'd0;
  localparam logic [2:0] c_md_multu = 3'd1;
  localparam logic [2:0] c_md_div   = 3'd2;
  localparam logic [2:0] c_md_divu  = 3'd3;
  localparam logic [2:0] c_md_mthi  = 3'd4;
  localparam logic [2:0] c_md_mtlo  = 3'd5;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Multi-cycle ops are the four codes below MTHI.
  function automatic logic is_timed_op(input logic [2:0] op);
    return (op <= c_md_divu);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == c_md_div) || (op == c_md_divu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_sched_unit_if.sv
// +----------------------------------------------------------------------+
// | md_sched_unit_if : E-stage request and HI/LO result bundle           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface md_sched_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, d_uses_md,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, d_uses_md,
    output busy, stall_req, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_sched_unit_calc.sv
// +----------------------------------------------------------------------+
// | md_calc : combinational 32x32 multiply and divide datapath           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module md_calc
  import md_sched_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_quo_m;
  logic [31:0] w_rem_m;
  logic [31:0] w_div_u;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic        w_rt_zero;

  assign w_rt_zero = (rt_val_i == 32'd0);

  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_prod_s = {{32{rs_val_i[31]}}, rs_val_i} * {{32{rt_val_i[31]}}, rt_val_i};
  assign w_prod_u = {32'd0, rs_val_i} * {32'd0, rt_val_i};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps instead of trapping.
  assign w_mag_a = rs_val_i[31] ? (~rs_val_i + 32'd1) : rs_val_i;
  assign w_mag_b = w_rt_zero ? 32'd1 : (rt_val_i[31] ? (~rt_val_i + 32'd1) : rt_val_i);
  assign w_quo_m = w_mag_a / w_mag_b;
  assign w_rem_m = w_mag_a % w_mag_b;

  assign w_div_u = w_rt_zero ? 32'd1 : rt_val_i;
  assign w_quo_u = rs_val_i / w_div_u;
  assign w_rem_u = rs_val_i % w_div_u;

  always_comb begin
    res_hi_o   = 32'd0;
    res_lo_o   = 32'd0;
    div_zero_o = 1'b0;
    case (op_i)
      c_md_mult:  {res_hi_o, res_lo_o} = w_prod_s;
      c_md_multu: {res_hi_o, res_lo_o} = w_prod_u;
      c_md_div: begin
        res_lo_o   = (rs_val_i[31] ^ rt_val_i[31]) ? (~w_quo_m + 32'd1) : w_quo_m;
        res_hi_o   = rs_val_i[31] ? (~w_rem_m + 32'd1) : w_rem_m;
        div_zero_o = w_rt_zero;
      end
      c_md_divu: begin
        res_lo_o   = w_quo_u;
        res_hi_o   = w_rem_u;
        div_zero_o = w_rt_zero;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_sched_unit.sv
// +----------------------------------------------------------------------+
// | md_sched_unit : multi-cycle MD scheduler owning HI/LO and stall_req  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module md_sched_unit
  import md_sched_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  md_sched_unit_if.slave  md
);

  localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_CYCLES);

  md_state_e          state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_zero_q, pend_zero_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_div_zero;
  logic               w_busy;

  md_calc u_calc (
    .op_i       (md.op),
    .rs_val_i   (md.rs_val),
    .rt_val_i   (md.rt_val),
    .res_hi_o   (w_res_hi),
    .res_lo_o   (w_res_lo),
    .div_zero_o (w_div_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_zero_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_zero_q <= pend_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_zero_d = pend_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          if (is_timed_op(md.op)) begin
            pend_hi_d   = w_res_hi;
            pend_lo_d   = w_res_lo;
            pend_zero_d = w_div_zero;
            cnt_d       = is_div_op(md.op) ? c_div_cnt : c_mult_cnt;
            state_d     = MD_RUN;
          end else if (md.op == c_md_mthi) begin
            hi_d = md.rs_val;
          end else if (md.op == c_md_mtlo) begin
            lo_d = md.rs_val;
          end
        end
      end
      MD_RUN: begin
        // A start arriving here is a hazard-unit violation and is dropped.
        if (cnt_q == c_cnt_w'(1)) begin
          if (!pend_zero_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign w_busy       = (state_q == MD_RUN);
  assign md.busy      = w_busy;
  assign md.stall_req = md.d_uses_md & (w_busy | md.start);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

endmodule

`default_nettype wire
